// File: rtl/vector_video_pkg.sv
// Shared types for the pixel-colour path: BBGGGRRR colour word and 4-bit palette index.
// Latency: n/a (types only). Backpressure: n/a.
package vector_video_pkg;

    typedef logic [7:0] color_t;
    typedef logic [3:0] palidx_t;

    localparam int PAL_ENTRIES = 16;

    // BBGGGRRR field positions
    localparam int RED_LSB = 0;
    localparam int RED_MSB = 2;
    localparam int GRN_LSB = 3;
    localparam int GRN_MSB = 5;
    localparam int BLU_LSB = 6;
    localparam int BLU_MSB = 7;

endpackage

// File: rtl/palette_regfile.sv
// 16x8 palette storage: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after we; read is combinational.
// Backpressure: none, a write is always accepted.
module palette_regfile
    import vector_video_pkg::*;
#(
    parameter color_t RESET_COLOR = 8'h00
) (
    input  logic    clk24,
    input  logic    reset,
    input  logic    we,
    input  palidx_t waddr,
    input  color_t  wdata,
    input  palidx_t raddr,
    output color_t  rdata
);

    color_t mem [PAL_ENTRIES];

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                mem[i] <= RESET_COLOR;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/palette_lut.sv
// Palette lookup: maps plane/border index to BBGGGRRR for the DAC; owns the port 0Ch write path.
// Latency: 2 pixel enables (ce12 in 512 mode) from sample to rgb; writes commit on the next ce_pixel.
// Backpressure: none; a write arriving while one is pending replaces it. Option macro: PALETTE_MODE512_EN.
module palette_lut
    import vector_video_pkg::*;
#(
    parameter color_t RESET_COLOR = 8'h00
) (
    input  logic    clk24,
    input  logic    reset,
    input  logic    ce12,
    input  logic    ce_pixel,
    input  palidx_t coloridx,
    input  logic    borderx,
    input  logic    blank,
    input  palidx_t border_idx,
    input  logic    mode512,
    input  logic    pal_wr,
    input  color_t  pal_data,
    output logic    wr_done,
    output color_t  rgb
);

    logic    adv;
    palidx_t pix_idx;
    palidx_t idx;
    palidx_t idx_d;
    logic    blank_d;
    color_t  rd_color;

    logic    pending;
    palidx_t wr_addr;
    color_t  wr_data;
    logic    commit;

`ifdef PALETTE_MODE512_EN
    logic half_phase;

    // Phase 0 carries the high plane pair, phase 1 the low pair.
    always_comb begin
        adv     = ce_pixel;
        pix_idx = coloridx;
        if (mode512) begin
            adv     = ce12;
            pix_idx = half_phase ? {2'b00, coloridx[1:0]} : {2'b00, coloridx[3:2]};
        end
    end

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            half_phase <= 1'b0;
        end else if (ce_pixel) begin
            half_phase <= 1'b0;
        end else if (ce12) begin
            half_phase <= ~half_phase;
        end
    end
`else
    logic unused_mode;

    assign adv         = ce_pixel;
    assign pix_idx     = coloridx;
    assign unused_mode = &{1'b0, mode512, ce12};
`endif

    assign idx    = borderx ? border_idx : pix_idx;
    assign commit = ce_pixel & pending;

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            idx_d   <= '0;
            blank_d <= 1'b0;
            rgb     <= RESET_COLOR;
        end else if (adv) begin
            idx_d   <= idx;
            blank_d <= blank;
            rgb     <= blank_d ? '0 : rd_color;
        end
    end

    // A request landing in the commit cycle re-arms pending for the next pixel.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= commit;
            if (pal_wr) begin
                wr_addr <= border_idx;
                wr_data <= pal_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    palette_regfile #(
        .RESET_COLOR(RESET_COLOR)
    ) u_regfile (
        .clk24(clk24),
        .reset(reset),
        .we   (commit),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(idx_d),
        .rdata(rd_color)
    );

endmodule

// File: tb/tb_palette_lut.sv
// Directed, table-driven bench for palette_lut; build with PALETTE_MODE512_EN to cover 512 mode.
module tb_palette_lut;
    import vector_video_pkg::*;

    logic       clk24 = 1'b0;
    logic       reset;
    logic       ce12;
    logic       ce_pixel;
    logic [3:0] coloridx;
    logic       borderx;
    logic       blank;
    logic [3:0] border_idx;
    logic       mode512;
    logic       pal_wr;
    logic [7:0] pal_data;
    logic       wr_done;
    logic [7:0] rgb;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int wd_cnt = 0;
    int wd0;

    typedef struct {
        logic       bx;
        logic [3:0] bi;
        logic [3:0] ci;
        logic       bl;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [10];

    palette_lut #(.RESET_COLOR(8'h00)) dut (
        .clk24     (clk24),
        .reset     (reset),
        .ce12      (ce12),
        .ce_pixel  (ce_pixel),
        .coloridx  (coloridx),
        .borderx   (borderx),
        .blank     (blank),
        .border_idx(border_idx),
        .mode512   (mode512),
        .pal_wr    (pal_wr),
        .pal_data  (pal_data),
        .wr_done   (wr_done),
        .rgb       (rgb)
    );

    always #5 clk24 = ~clk24;

    always @(negedge clk24) if (wr_done === 1'b1) wd_cnt++;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Enables are set for the upcoming edge; ce_pixel every 4th clk24, ce12 every 2nd.
    task automatic clk_cycle();
        @(posedge clk24);
        #1;
        cyc++;
        ce12     = (cyc % 2 == 0);
        ce_pixel = (cyc % 4 == 0);
    endtask

    task automatic next_pixel();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            hit = ce_pixel;
            clk_cycle();
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ce_pixel_timeout: got none expected enable within 8 cycles");
        end
    endtask

    task automatic next_ce12(output logic was_pix);
        logic hit;
        hit     = 1'b0;
        was_pix = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
            hit     = ce12;
            was_pix = ce_pixel;
            clk_cycle();
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ce12_timeout: got none expected enable within 4 cycles");
        end
    endtask

    task automatic write_pal(input logic [3:0] a, input logic [7:0] d);
        border_idx = a;
        pal_data   = d;
        pal_wr     = 1'b1;
        clk_cycle();
        pal_wr     = 1'b0;
        next_pixel();
    endtask

    task automatic read_vec(input logic bx, input logic [3:0] bi, input logic [3:0] ci, input logic bl);
        borderx    = bx;
        border_idx = bi;
        coloridx   = ci;
        blank      = bl;
        next_pixel();
        next_pixel();
    endtask

    initial begin
        logic wp;
        reset = 1'b1; ce12 = 1'b0; ce_pixel = 1'b0; coloridx = '0; borderx = 1'b0;
        blank = 1'b0; border_idx = '0; mode512 = 1'b0; pal_wr = 1'b0; pal_data = '0;
        repeat (3) @(posedge clk24);
        #1;
        check("reset_rgb", rgb, 8'h00);
        check("reset_wr_done", {7'd0, wr_done}, 8'h00);
        reset = 1'b0;
        clk_cycle();
        check("post_reset_rgb", rgb, 8'h00);
        check("post_reset_wr_done", {7'd0, wr_done}, 8'h00);

        for (int i = 0; i < 16; i++) begin
            read_vec(1'b0, 4'd0, 4'(i), 1'b0);
            check($sformatf("reset_entry_%0d", i), rgb, 8'h00);
        end

        // Single write, commit pulse, then latency of the read path
        wd0 = wd_cnt;
        write_pal(4'd5, 8'hE3);
        check("wr_done_on_commit", {7'd0, wr_done}, 8'h01);
        clk_cycle();
        check("wr_done_single_cycle", {7'd0, wr_done}, 8'h00);
        check("wr_done_count_1", 8'(wd_cnt - wd0), 8'd1);
        coloridx = 4'd5;
        next_pixel();
        check("latency_1_enable_old", rgb, 8'h00);
        next_pixel();
        check("latency_2_enable_new", rgb, 8'hE3);

        // Two requests inside one pixel: last wins, one commit
        wd0 = wd_cnt;
        border_idx = 4'd3; pal_data = 8'h11; pal_wr = 1'b1;
        clk_cycle();
        pal_data = 8'h22;
        clk_cycle();
        pal_wr = 1'b0;
        next_pixel();
        next_pixel();
        next_pixel();
        check("double_wr_one_commit", 8'(wd_cnt - wd0), 8'd1);

        // Request in the commit cycle; S2 reads the committing entry
        coloridx = 4'd6; borderx = 1'b0; blank = 1'b0;
        next_pixel();
        wd0 = wd_cnt;
        border_idx = 4'd6; pal_data = 8'h66; pal_wr = 1'b1;
        clk_cycle();
        pal_wr = 1'b0;
        for (int i = 0; i < 4 && !ce_pixel; i++) clk_cycle();
        border_idx = 4'd7; pal_data = 8'h77; pal_wr = 1'b1;
        clk_cycle();
        pal_wr = 1'b0;
        check("rbw_old_value", rgb, 8'h00);
        check("commit_a_wr_done", {7'd0, wr_done}, 8'h01);
        next_pixel();
        check("commit_b_wr_done", {7'd0, wr_done}, 8'h01);
        clk_cycle();
        check("commit_ab_count", 8'(wd_cnt - wd0), 8'd2);

        write_pal(4'd4, 8'h1C);

        vt[0] = '{1'b0, 4'd0, 4'd5, 1'b0, 8'hE3};
        vt[1] = '{1'b0, 4'd0, 4'd3, 1'b0, 8'h22};
        vt[2] = '{1'b0, 4'd0, 4'd6, 1'b0, 8'h66};
        vt[3] = '{1'b0, 4'd0, 4'd7, 1'b0, 8'h77};
        vt[4] = '{1'b1, 4'd4, 4'd0, 1'b0, 8'h1C};
        vt[5] = '{1'b1, 4'd4, 4'd5, 1'b0, 8'h1C};
        vt[6] = '{1'b0, 4'd9, 4'd4, 1'b0, 8'h1C};
        vt[7] = '{1'b0, 4'd4, 4'd5, 1'b1, 8'h00};
        vt[8] = '{1'b1, 4'd5, 4'd0, 1'b0, 8'hE3};
        vt[9] = '{1'b0, 4'd0, 4'd0, 1'b0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            read_vec(vt[i].bx, vt[i].bi, vt[i].ci, vt[i].bl);
            check($sformatf("vec_%0d", i), rgb, vt[i].exp);
        end

        // Border colour with blanking edges and hold between enables
        read_vec(1'b1, 4'd4, 4'd0, 1'b0);
        check("border_unblanked", rgb, 8'h1C);
        borderx = 1'b0;
        clk_cycle();
        check("hold_between_enables", rgb, 8'h1C);
        borderx = 1'b1;
        blank = 1'b1;
        next_pixel();
        check("blank_rise_plus1", rgb, 8'h1C);
        next_pixel();
        check("blank_rise_plus2", rgb, 8'h00);
        blank = 1'b0;
        next_pixel();
        check("blank_fall_plus1", rgb, 8'h00);
        next_pixel();
        check("blank_fall_plus2", rgb, 8'h1C);
        borderx = 1'b0;

`ifdef PALETTE_MODE512_EN
        write_pal(4'd2, 8'hAA);
        write_pal(4'd1, 8'h55);
        coloridx = 4'b1001; blank = 1'b0; mode512 = 1'b1;
        for (int i = 0; i < 4; i++) next_ce12(wp);
        for (int i = 0; i < 6; i++) begin
            next_ce12(wp);
            check($sformatf("m512_%0d", i), rgb, wp ? 8'hAA : 8'h55);
        end
        mode512 = 1'b0;
`else
        mode512 = 1'b1;
        read_vec(1'b0, 4'd0, 4'd5, 1'b0);
        check("mode512_ignored", rgb, 8'hE3);
        mode512 = 1'b0;
`endif

        // Reset with a write pending discards it
        next_pixel();
        wd0 = wd_cnt;
        border_idx = 4'd9; pal_data = 8'h99; pal_wr = 1'b1;
        clk_cycle();
        pal_wr = 1'b0;
        reset = 1'b1;
        clk_cycle();
        check("reset_mid_rgb", rgb, 8'h00);
        reset = 1'b0;
        read_vec(1'b0, 4'd0, 4'd9, 1'b0);
        next_pixel();
        check("reset_pending_no_done", 8'(wd_cnt - wd0), 8'd0);
        check("reset_pending_entry", rgb, 8'h00);
        read_vec(1'b0, 4'd0, 4'd5, 1'b0);
        check("reset_clears_entry5", rgb, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
